sram_fib_master: RTL and testbench

- Memory-side initiator for the single-port SRAM in the Fibonacci datapath.
- On `start`, generates the first N Fibonacci terms modulo 2^DATA_WIDTH and writes them to SRAM addresses 0..N-1. Each term is computed from two read-backs, so memory is the only operand storage.
- Then reads the terms back in address order and presents them on a valid/ready output stream.
- Sits between the top-level control/IO wrapper and the SRAM: it drives we/oe/address/data_in and consumes the SRAM's data_out.

---
 rtl/sram_fib_master.sv | 160 ++++++++++++++++
 tb/tb_sram_fib_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_fib_master.sv
// SRAM-side initiator that builds the first N Fibonacci terms in memory, using only
// SRAM read-backs as operands, then streams them back out over a valid/ready port.
module sram_fib_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_terms,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] MAX_TERMS = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO       = (ADDR_WIDTH+1)'(2);

    typedef enum logic [3:0] {
        IDLE, INIT0, INIT1, RD_A, RD_B, WR, STREAM_RD, STREAM_WAIT, DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   n_reg, n_next, i_reg, i_next, k_reg, k_next;
    logic [DATA_WIDTH-1:0] a_reg, a_next, out_data_reg, out_data_next;
    logic                  overflow_reg, overflow_next;
    logic [DATA_WIDTH:0]   sum;

    logic                  we_reg, we_next, oe_reg, oe_next;
    logic [ADDR_WIDTH:0]   addr_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  out_valid_reg, busy_reg, done_reg;

    // Second operand comes straight off the SRAM in RD_B; the carry bit feeds overflow.
    assign sum = {1'b0, a_reg} + {1'b0, mem_rdata};

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        i_next        = i_reg;
        k_next        = k_reg;
        a_next        = a_reg;
        out_data_next = out_data_reg;
        overflow_next = overflow_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    n_next        = (n_terms > MAX_TERMS) ? MAX_TERMS : n_terms;
                    overflow_next = 1'b0;
                    state_next    = (n_next == '0) ? DONE : INIT0;
                end
            end
            INIT0: begin
                k_next     = '0;
                state_next = (n_reg == ONE) ? STREAM_RD : INIT1;
            end
            INIT1: begin
                i_next     = TWO;
                k_next     = '0;
                state_next = (n_reg == TWO) ? STREAM_RD : RD_A;
            end
            RD_A: begin
                a_next     = mem_rdata;
                state_next = RD_B;
            end
            RD_B: begin
                overflow_next = overflow_reg | sum[DATA_WIDTH];
                state_next    = WR;
            end
            WR: begin
                i_next     = i_reg + ONE;
                k_next     = '0;
                state_next = (i_reg + ONE == n_reg) ? STREAM_RD : RD_A;
            end
            STREAM_RD: begin
                out_data_next = mem_rdata;
                state_next    = STREAM_WAIT;
            end
            STREAM_WAIT: begin
                if (out_ready) begin
                    k_next     = k_reg + ONE;
                    state_next = (k_reg + ONE == n_reg) ? DONE : STREAM_RD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes are decoded from the upcoming state so they are registered
    // yet line up exactly with the cycle the FSM spends in that state.
    always_comb begin
        we_next    = 1'b0;
        oe_next    = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        case (state_next)
            INIT0:     we_next = 1'b1;
            INIT1:     begin we_next = 1'b1; addr_next = ONE; wdata_next = 1; end
            RD_A:      begin oe_next = 1'b1; addr_next = i_next - TWO; end
            RD_B:      begin oe_next = 1'b1; addr_next = i_next - ONE; end
            WR:        begin we_next = 1'b1; addr_next = i_next; wdata_next = sum[DATA_WIDTH-1:0]; end
            STREAM_RD: begin oe_next = 1'b1; addr_next = k_next; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            n_reg         <= '0;
            i_reg         <= '0;
            k_reg         <= '0;
            a_reg         <= '0;
            out_data_reg  <= '0;
            overflow_reg  <= 1'b0;
            we_reg        <= 1'b0;
            oe_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            n_reg         <= n_next;
            i_reg         <= i_next;
            k_reg         <= k_next;
            a_reg         <= a_next;
            out_data_reg  <= out_data_next;
            overflow_reg  <= overflow_next;
            we_reg        <= we_next;
            oe_reg        <= oe_next;
            addr_reg      <= addr_next[ADDR_WIDTH-1:0];
            wdata_reg     <= wdata_next;
            out_valid_reg <= (state_next == STREAM_WAIT);
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == DONE);
        end
    end

    assign mem_we    = we_reg;
    assign mem_oe    = oe_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_sram_fib_master.sv
// Bench for sram_fib_master: SRAM model, randomized runs and backpressure, checked
// against a plain-arithmetic Fibonacci reference.
module tb_sram_fib_master;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [AW:0]   n_terms;
    logic          mem_we, mem_oe, out_valid, busy, done, overflow;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, out_data;

    sram_fib_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, n_writes, n_done, n_both, n_valid, first_wr, last_wr, done_cyc;
    int stall_bad, stall_cyc, stall_val_bad, low_cnt, ready_mode;
    logic [DW-1:0] got_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (mem_we && mem_oe) n_both++;
        if (mem_we) begin
            if (n_writes == 0) first_wr = cyc;
            last_wr = cyc;
            n_writes++;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (out_valid) n_valid++;
        if (prev_stall && (out_data !== prev_data || out_valid !== 1'b1)) stall_bad++;
        if (out_valid && !out_ready) begin
            stall_cyc++;
            if (out_data !== 8'd1) stall_val_bad++;
        end
        if (out_valid && out_ready) got_q.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = 5-cycle stall on the 2nd term.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (got_q.size() == 1 && out_valid && low_cnt < 5) begin
                        out_ready = 1'b0;
                        low_cnt++;
                    end else out_ready = 1'b1;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fib_mod(input int idx);
        int x = 0, y = 1, t;
        for (int j = 0; j < idx; j++) begin t = (x + y) % 256; x = y; y = t; end
        return x;
    endfunction

    function automatic bit fib_carry(input int n);
        bit c = 0;
        for (int j = 2; j < n; j++) if (fib_mod(j - 1) + fib_mod(j - 2) > 255) c = 1;
        return c;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_writes = 0; n_done = 0; n_both = 0; n_valid = 0; first_wr = 0; last_wr = 0;
        done_cyc = 0; stall_bad = 0; stall_cyc = 0; stall_val_bad = 0; low_cnt = 0;
        got_q.delete();
    endtask

    task automatic run(input int req, input int mode);
        int n, start_cyc, lim;
        n = (req > 16) ? 16 : req;
        clear_mon();
        ready_mode = mode;
        start = 1'b1;
        n_terms = (AW+1)'(req);
        start_cyc = cyc;
        step();
        start = 1'b0;
        for (lim = 0; lim < 3000 && n_done == 0; lim++) begin
            if (busy && !done && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                n_terms = (AW+1)'($urandom_range(0, 31));
            end
            step();
            start = 1'b0;
        end
        chk($sformatf("n%0d_done_seen", req), (n_done > 0), 1);
        step();
        step();
        chk($sformatf("n%0d_done_pulses", req), n_done, 1);
        chk($sformatf("n%0d_idle_busy", req), busy, 0);
        chk($sformatf("n%0d_handshakes", req), got_q.size(), n);
        for (int j = 0; j < got_q.size() && j < n; j++)
            chk($sformatf("n%0d_stream[%0d]", req, j), got_q[j], fib_mod(j));
        chk($sformatf("n%0d_writes", req), n_writes, n);
        for (int j = 0; j < n; j++)
            chk($sformatf("n%0d_sram[%0d]", req, j), sram[j], fib_mod(j));
        if (n >= 2)
            chk($sformatf("n%0d_gen_cycles", req), last_wr - first_wr + 1, 2 + 3 * (n - 2));
        if (n == 0) begin
            chk("n0_done_latency_le2", (done_cyc - start_cyc <= 2), 1);
            chk("n0_no_valid", n_valid, 0);
        end
        chk($sformatf("n%0d_overflow", req), overflow, fib_carry(n));
        chk($sformatf("n%0d_we_oe_excl", req), n_both, 0);
        chk($sformatf("n%0d_stall_stable", req), stall_bad, 0);
        $display("run n_terms=%0d N=%0d mode=%0d handshakes=%0d overflow=%0b",
                 req, n, mode, got_q.size(), overflow);
    endtask

    initial begin
        ready_mode = 0;
        clear_mon();
        for (int j = 0; j < (1 << AW); j++) sram[j] = DW'($urandom);
        rst = 1'b1; start = 1'b0; n_terms = '0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_oe", mem_oe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();

        // Reset in the middle of generation.
        start = 1'b1; n_terms = 5'd16;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("midrun_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_busy", busy, 0);
        chk("midrun_we", mem_we, 0);
        chk("midrun_oe", mem_oe, 0);
        chk("midrun_valid", out_valid, 0);
        step();
        run(5, 0);

        run(8, 0);
        run(16, 0);
        chk("overflow_sticky_idle", overflow, 1);
        repeat (3) step();
        chk("overflow_sticky_later", overflow, 1);
        run(31, 1);
        run(0, 0);
        run(1, 0);
        run(2, 1);

        run(4, 2);
        chk("bp_stall_cycles", stall_cyc, 5);
        chk("bp_stall_value", stall_val_bad, 0);

        for (int r = 0; r < 6; r++) run($urandom_range(0, 31), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
